// File: rtl/hazard_unit.sv
// Decode interlock: load-use, long-op scoreboard RAW/WAW and long-unit structural stalls.
// Optional stall counters are built when HAZARD_STALL_CNT_EN is defined.
module hazard_unit #(
   parameter int REG_ADDR_W = 5,
   parameter int NUM_REGS   = 32,
   parameter int CNT_W      = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  id_valid,
   input  logic [REG_ADDR_W-1:0] id_rs1_addr,
   input  logic [REG_ADDR_W-1:0] id_rs2_addr,
   input  logic                  id_uses_rs1,
   input  logic                  id_uses_rs2,
   input  logic [REG_ADDR_W-1:0] id_rd_addr,
   input  logic                  id_writes_rd,
   input  logic                  id_is_long,
   input  logic                  ex_valid,
   input  logic                  ex_is_load,
   input  logic [REG_ADDR_W-1:0] ex_rd_addr,
   input  logic                  long_busy,
   input  logic                  long_done,
   input  logic [REG_ADDR_W-1:0] long_rd_addr,
   input  logic                  flush,
   output logic                  stall,
   output logic                  bubble,
   output logic                  long_issue,
   output logic [1:0]            stall_cause,
   output logic [NUM_REGS-1:0]   scoreboard,
   output logic [CNT_W-1:0]      load_stall_cnt,
   output logic [CNT_W-1:0]      long_stall_cnt
);

   typedef enum logic [1:0] {
      RUN         = 2'd0,
      LOAD_WAIT   = 2'd1,
      SB_WAIT     = 2'd2,
      STRUCT_WAIT = 2'd3
   } state_t;

   state_t              state;
   state_t              cause_now;
   logic                lu;
   logic                sb;
   logic                st;
   logic                sb_set;
   logic                sb_clr;
   logic [NUM_REGS-1:0] sb_next;

   // Decode advances only when stall is low; an instruction in decode with
   // id_valid high is consumed on the edge where stall==0 (ready = ~stall).
   always_comb begin
      lu = ex_valid && ex_is_load && (ex_rd_addr != '0) &&
           ((id_uses_rs1 && (id_rs1_addr == ex_rd_addr)) ||
            (id_uses_rs2 && (id_rs2_addr == ex_rd_addr)));
      sb = (id_uses_rs1  && scoreboard[id_rs1_addr]) ||
           (id_uses_rs2  && scoreboard[id_rs2_addr]) ||
           (id_writes_rd && scoreboard[id_rd_addr]);
      st = id_is_long && long_busy;
   end

   assign stall      = id_valid && !flush && (lu || sb || st);
   assign bubble     = stall;
   assign long_issue = id_valid && !flush && id_is_long && !stall;

   always_comb begin
      cause_now = RUN;
      if (stall) begin
         if (lu)      cause_now = LOAD_WAIT;
         else if (sb) cause_now = SB_WAIT;
         else         cause_now = STRUCT_WAIT;
      end
   end

   // x0 is never tracked; a set on the same index as a clear must win
   // because the newly issued op is the younger writer.
   assign sb_set = long_issue && id_writes_rd && (id_rd_addr != '0);
   assign sb_clr = long_done && (long_rd_addr != '0);

   always_comb begin
      sb_next = scoreboard;
      if (sb_clr) sb_next[long_rd_addr] = 1'b0;
      if (sb_set) sb_next[id_rd_addr]   = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         scoreboard <= '0;
         state      <= RUN;
      end else begin
         scoreboard <= sb_next;
         state      <= cause_now;
      end
   end

   assign stall_cause = state;

`ifdef HAZARD_STALL_CNT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         load_stall_cnt <= '0;
         long_stall_cnt <= '0;
      end else begin
         if ((cause_now == LOAD_WAIT) && (load_stall_cnt != '1))
            load_stall_cnt <= load_stall_cnt + CNT_W'(1);
         if (((cause_now == SB_WAIT) || (cause_now == STRUCT_WAIT)) &&
             (long_stall_cnt != '1))
            long_stall_cnt <= long_stall_cnt + CNT_W'(1);
      end
   end
`else
   assign load_stall_cnt = '0;
   assign long_stall_cnt = '0;
`endif

endmodule
